// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/redirect control for the 5-stage pipeline with stall counters
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_req,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_memwb,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_istall,
  output logic [31:0] perf_dstall
);
  typedef enum logic [1:0] {RUN, DROP, REDIR} state_t;
  state_t state;
  logic [31:0] tgt_q;
  logic imiss, dmiss, run, drop, redir, br_ok;
  assign imiss = imem_req & ~imem_resp;
  assign dmiss = dmem_req & ~dmem_resp;
  assign run = state == RUN;
  assign drop = state == DROP;
  assign redir = state == REDIR;
  assign br_ok = run & br_taken & ~dmiss;
  assign stall_if = dmiss | imiss | drop;
  assign stall_id = dmiss;
  assign stall_ex = dmiss;
  assign stall_mem = dmiss;
  assign flush_memwb = dmiss;
  assign flush_ifid = drop | redir | (~dmiss & (imiss | br_ok));
  assign flush_idex = br_ok;
  assign redirect_valid = redir | (br_ok & ~imiss);
  assign redirect_pc = (run & br_taken) ? br_target : tgt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      tgt_q <= '0;
      perf_istall <= '0;
      perf_dstall <= '0;
    end else begin
      if ((stall_if & ~dmiss) | drop) perf_istall <= perf_istall + 32'd1;
      if (dmiss) perf_dstall <= perf_dstall + 32'd1;
      // a taken branch behind an unabortable fetch parks its target until that fetch returns
      case (state)
        RUN: if (br_ok & imiss) begin
          tgt_q <= br_target;
          state <= imem_resp ? REDIR : DROP;
        end
        DROP: if (imem_resp) state <= REDIR;
        REDIR: if (!dmiss) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline; the producer-side counterpart to operand forwarding. It tracks outstanding instruction- and data-memory requests and taken-branch redirects, and drives per-stage stall and bubble controls. It also keeps a redirect target alive across an in-flight instruction fetch that cannot be aborted, and counts stall cycles for performance monitoring. It sits beside the pipeline registers and is the only source of their load-enable and flush controls.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  in  1  fetch stage has an instruction read outstanding or starting
- imem_resp  in  1  instruction data valid this cycle (1-cycle pulse)
- dmem_req  in  1  MEM stage load/store is requesting the data memory
- dmem_resp  in  1  data response/ack this cycle (1-cycle pulse)
- br_taken  in  1  EX stage resolved a taken branch or jump this cycle
- br_target  in  32  redirect PC from EX
- stall_if  out  1  hold PC and IF/ID
- stall_id  out  1  hold ID/EX
- stall_ex  out  1  hold EX/MEM
- stall_mem  out  1  hold MEM/WB input side (MEM stage frozen)
- flush_ifid  out  1  load bubble into IF/ID
- flush_idex  out  1  load bubble into ID/EX
- flush_memwb  out  1  load bubble into MEM/WB
- redirect_valid  out  1  PC loads redirect_pc this cycle
- redirect_pc  out  32  redirect target
- perf_istall  out  32  cycles of fetch stall (wraps)
- perf_dstall  out  32  cycles of data-memory stall (wraps)

## Operation
- Combinational miss terms: imiss = imem_req & ~imem_resp; dmiss = dmem_req & ~dmem_resp.
- dmiss has top priority. It asserts stall_if, stall_id, stall_ex, stall_mem and flush_memwb. br_taken is ignored while dmiss is set, because EX is frozen and re-presents the branch later.
- imiss with no dmiss asserts stall_if and flush_ifid. ID and later stages keep flowing.
- State machine: RUN, DROP, REDIR. Registered target latch tgt_q holds 32 bits.
- RUN, br_taken and no dmiss, no imiss:
  - redirect_valid=1, redirect_pc=br_target, flush_ifid=1, flush_idex=1.
  - Remain in RUN.
- RUN, br_taken and no dmiss, imiss set:
  - flush_idex=1, flush_ifid=1; tgt_q <= br_target.
  - If imem_resp is also set, go to REDIR; otherwise go to DROP.
  - redirect_valid=0 this cycle.
- DROP (wrong-path fetch in flight):
  - stall_if=1 and flush_ifid=1 every cycle.
  - On imem_resp the wrong-path data is discarded via flush_ifid, and the state goes to REDIR.
  - br_taken is ignored, since EX holds a bubble.
  - dmiss in DROP also asserts the full dmiss stall set.
- REDIR:
  - redirect_valid=1, redirect_pc=tgt_q, flush_ifid=1.
  - Go to RUN the next cycle unconditionally, unless dmiss is set; then hold REDIR.
- In RUN, redirect_pc=br_target when br_taken, else tgt_q.
- Counters:
  - perf_istall increments every cycle stall_if is set while dmiss=0, or every cycle in DROP.
  - perf_dstall increments every cycle dmiss=1.
  - Both wrap modulo 2^32.

## Timing
- Reset (async assert, sync release): state=RUN, tgt_q=0, perf_istall=perf_dstall=0.
- Every output is combinational from state and inputs. With inputs idle after reset, every stall/flush/redirect output is 0 and redirect_pc=0.
- Memory hit (resp in the same cycle as req): zero stall cycles.
- Taken-branch redirect latency with no fetch outstanding: 0 cycles (same cycle).
- Redirect with a fetch outstanding: redirect_valid comes exactly 1 cycle after the cycle in which imem_resp is seen.
- Simultaneous imiss and dmiss: dmiss output set only, plus stall_if (already included). perf_dstall increments, perf_istall does not.
- rst_n asserted in DROP or REDIR: immediate return to RUN. The pending redirect is lost, and the fetch unit is reset by the same rst_n.

## Test plan
- Reset, then all inputs 0 -> every output 0, counters 0, state RUN.
- dmem_req=1 for 3 cycles, dmem_resp on cycle 3 -> stall_if/id/ex/mem and flush_memwb high for cycles 1–2, perf_dstall=2.
- imem_req=1 with no resp for 4 cycles -> stall_if and flush_ifid high for 4 cycles, stall_id=0, perf_istall=4.
- br_taken, br_target=0x60000040, no misses -> same-cycle redirect_valid=1, redirect_pc=0x60000040, flush_ifid=flush_idex=1.
- br_taken with target 0x1234 during imiss, imem_resp 3 cycles later -> state DROP; flush_ifid stays high through the resp; redirect_valid=1 with redirect_pc=0x1234 in the following cycle only.
- rst_n pulsed low while in DROP -> immediate RUN, counters 0, no redirect issued afterward.
